// File: rtl/cordic_pkg.sv
// Shared definitions for the phase source and the quarter-wave CORDIC sine stage.
package cordic_pkg;

   // Width of the quarter-wave phase handed to the CORDIC stage.
   localparam int unsigned QPH_W = 16;

   // Fixed-point CORDIC gain constant, shared with the CORDIC stage.
   localparam logic [QPH_W-1:0] CORDIC_GAIN = 16'hDBD9;

   // Quadrant of a full-cycle phase.
   typedef enum logic [1:0] {
      Q0 = 2'd0,
      Q1 = 2'd1,
      Q2 = 2'd2,
      Q3 = 2'd3
   } quadrant_t;

   // Sine is negative in the second half of the cycle.
   function automatic logic quad_is_neg(input quadrant_t q);
      return (q == Q2) || (q == Q3);
   endfunction

   // Quarter phase runs backwards (mirrored) in the odd quadrants.
   function automatic logic quad_is_mirrored(input quadrant_t q);
      return (q == Q1) || (q == Q3);
   endfunction

endpackage : cordic_pkg

// File: rtl/qph_fold.sv
// Folds a full-cycle phase into quadrant, quarter phase and sine sign.
module qph_fold
   import cordic_pkg::*;
#(
   parameter int unsigned ACC_W = 32
) (
   input  logic [ACC_W-1:0] i_ph,
   output logic [QPH_W-1:0] o_qph,
   output quadrant_t        o_quad,
   output logic             o_neg
);

   logic [1:0]       q_bits;
   logic [QPH_W-1:0] frac;
   quadrant_t        quad;
   // Bits below the quarter-phase field are truncated on purpose; they only
   // matter upstream as carries into the accumulator sum.
   logic [ACC_W-1:0] ph_unused;

   assign ph_unused = i_ph;

   // Split the phase and mirror the quarter phase in the odd quadrants.
   always_comb begin
      q_bits = i_ph[ACC_W-1 -: 2];
      frac   = i_ph[ACC_W-3 -: QPH_W];
      quad   = quadrant_t'(q_bits);
      o_quad = quad;
      o_neg  = quad_is_neg(quad);
      o_qph  = quad_is_mirrored(quad) ? ~frac : frac;
   end

endmodule : qph_fold

// File: rtl/phase_nco.sv
// Phase accumulator NCO producing folded quarter phase samples behind a
// valid/ready output register; backpressure freezes phase advance.
module phase_nco
   import cordic_pkg::*;
#(
   parameter int unsigned ACC_W = 32
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_en,
   input  logic             i_ftw_wr,
   input  logic [ACC_W-1:0] i_ftw,
   input  logic [ACC_W-1:0] i_poff,
   input  logic             i_sync,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [15:0]      o_qph,
   output logic [1:0]       o_quad,
   output logic             o_neg
);

   logic [ACC_W-1:0] acc_q, acc_d;
   logic [ACC_W-1:0] ftw_q, ftw_d;
   logic             valid_q, valid_d;
   logic [QPH_W-1:0] qph_q, qph_d;
   quadrant_t        quad_q, quad_d;
   logic             neg_q, neg_d;

   logic [ACC_W-1:0] acc_eff;
   logic [ACC_W-1:0] ph;
   logic             load;
   logic [QPH_W-1:0] fold_qph;
   quadrant_t        fold_quad;
   logic             fold_neg;

   // Full phase of the sample that would be loaded this cycle.
   always_comb begin
      acc_eff = i_sync ? '0 : acc_q;
      ph      = acc_eff + i_poff;
   end

   qph_fold #(
      .ACC_W (ACC_W)
   ) u_fold (
      .i_ph   (ph),
      .o_qph  (fold_qph),
      .o_quad (fold_quad),
      .o_neg  (fold_neg)
   );

   // Handshake, accumulator step and FTW update.
   always_comb begin
      load    = i_en && (!valid_q || i_ready);
      acc_d   = acc_q;
      ftw_d   = i_ftw_wr ? i_ftw : ftw_q;
      valid_d = valid_q;
      qph_d   = qph_q;
      quad_d  = quad_q;
      neg_d   = neg_q;
      if (load) begin
         // Step uses the FTW register as it stood before any same-cycle write.
         acc_d   = acc_eff + ftw_q;
         valid_d = 1'b1;
         qph_d   = fold_qph;
         quad_d  = fold_quad;
         neg_d   = fold_neg;
      end else if (i_ready) begin
         valid_d = 1'b0;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         acc_q   <= '0;
         ftw_q   <= '0;
         valid_q <= 1'b0;
         qph_q   <= '0;
         quad_q  <= Q0;
         neg_q   <= 1'b0;
      end else begin
         acc_q   <= acc_d;
         ftw_q   <= ftw_d;
         valid_q <= valid_d;
         qph_q   <= qph_d;
         quad_q  <= quad_d;
         neg_q   <= neg_d;
      end
   end

   assign o_valid = valid_q;
   assign o_qph   = qph_q;
   assign o_quad  = quad_q;
   assign o_neg   = neg_q;

endmodule : phase_nco

// File: doc/phase_nco.md
Name: phase_nco

Overview:
- Upstream phase source for the quarter-wave CORDIC sine stage.
- Runs an ACC_W-bit phase accumulator stepped by a frequency tuning word (FTW), adds a phase offset, and folds the full-cycle phase into a 16-bit quarter phase for the CORDIC `i_qph` input.
- Also emits the quadrant and a negate flag so a downstream sign stage can rebuild a full-wave sine.
- Output is a registered sample behind a valid/ready handshake, so backpressure freezes phase advance.

Parameters:
- ACC_W, 32, accumulator/FTW/offset width in bits; must be >= 18 (2 quadrant bits + 16 quarter-phase bits).

Ports:
- i_clk  input  1  clock
- i_rst  input  1  synchronous active-high reset
- i_en  input  1  allow new samples to be generated
- i_ftw_wr  input  1  load i_ftw into the FTW register this cycle
- i_ftw  input  ACC_W  frequency tuning word (phase step per accepted sample)
- i_poff  input  ACC_W  phase offset, sampled live on each sample load
- i_sync  input  1  restart phase: next loaded sample uses accumulator value 0
- o_valid  output  1  output sample register holds a sample
- i_ready  input  1  consumer accepts sample (transfer when o_valid && i_ready)
- o_qph  output  16  folded quarter phase; 0 = 0 deg, 0xFFFF = just under 90 deg
- o_quad  output  2  quadrant of the full phase (0..3)
- o_neg  output  1  sine is negative (quadrant 2 or 3)

Behaviour:
- Reset, in any cycle including mid-stream: acc=0, ftw=0, o_valid=0, o_qph=0, o_quad=0, o_neg=0. Reset overrides every other input that cycle.
- Load condition: `load = i_en && (!o_valid || i_ready)`.
- Full phase: `ph = acc_eff + i_poff`, mod 2^ACC_W.
  - acc_eff = 0 when i_sync=1, else acc.
- Fold of ph:
  - q = ph[ACC_W-1:ACC_W-2]
  - f = ph[ACC_W-3 -: 16] (lower bits truncated, no rounding)
  - o_qph = f when q is 0 or 2; o_qph = ~f (0xFFFF-f) when q is 1 or 3. No overflow is possible.
  - o_neg = q[1]; o_quad = q.
- On load (registered, 1-cycle latency from load to o_valid=1):
  - o_qph, o_quad, o_neg <= fold(ph); o_valid <= 1.
  - acc <= acc_eff + ftw, using the FTW register value before any write in the same cycle.
- No load while o_valid && !i_ready:
  - Outputs held stable; acc not advanced.
  - i_sync in such a cycle is ignored (it takes effect only on a load cycle).
- No load with i_en=0 and transfer:
  - o_valid <= 0; acc held; outputs hold their last values.
- Throughput: one sample per cycle with i_ready=1, i_en=1.
- i_ftw_wr: ftw <= i_ftw; the new value is used from the next load after the write cycle.
- Accumulator wraps modulo 2^ACC_W silently (intended phase wrap).
- i_poff is not registered inside the block; changing it only affects samples loaded afterwards.
- Simultaneous i_sync and load: the sample is at phase i_poff, and acc <= ftw.

Decomposition:
- Shared cordic_pkg:
  - QPH_W = 16
  - quadrant typedef (2-bit enum Q0..Q3)
  - DBD9 gain constant, shared with the CORDIC stage
- One natural combinational sub-module, qph_fold: ph in -> qph, quad, neg out. Reused later by a cosine/quadrature variant.
- Accumulator, FTW register and handshake stay in phase_nco.

Test Plan:
- Quadrant walk: ftw=0x40000000, poff=0, i_ready=1, i_en=1, i_sync pulse on the first load. Outputs (qph, quad, neg) = (0x0000,0,0), (0xFFFF,1,0), (0x0000,2,1), (0xFFFF,3,1), then repeat.
- Offset fold: acc=0 via sync, poff=0x20000000 -> qph=0x8000, quad=0, neg=0; poff=0x60000000 -> qph=0x7FFF, quad=1.
- Backpressure: ftw=0x100, after the first sample hold i_ready=0 for 3 cycles. o_valid=1 and o_qph unchanged for those 3 cycles; the next sample after ready returns is phase 0x100, not 0x400.
- Wrap: sync, then ftw=0x80000000+0x100 for three loads. Phases are 0x0, 0x80000100, 0x00000200; the third sample has quad=0, neg=0.
- FTW write during streaming: write 0x200 in the same cycle as a load using ftw 0x100. The next sample is +0x100, subsequent samples step by +0x200.
- Reset mid-stream and enable gating:
  - Assert i_rst with o_valid=1, i_ready=0. Next cycle o_valid=0, outputs 0, and the first post-reset sample is phase poff.
  - i_en=0 with i_ready=1 drops o_valid after one cycle.
